iir_out_decim: RTL and testbench

IIR_OUT_DECIM -- requirements
Module: iir_out_decim

---
 rtl/iir_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/iir_out_decim.sv | 113 +++++++++++
 tb/tb_iir_out_decim.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared fixed-point definitions for the IIR filter datapath and its output stage.
// Default sample formats are Q4.13 into the output stage and Q4.12 out of it.
package iir_pkg;

    localparam int IIR_IN_LEN   = 17;
    localparam int IIR_IN_FRAC  = 13;
    localparam int IIR_OUT_LEN  = 16;
    localparam int IIR_OUT_FRAC = 12;

    typedef enum logic [1:0] {
        SAT_PASS,
        SAT_POS,
        SAT_NEG
    } sat_e;

    // Saturation limits of a signed sample that is len bits wide.
    function automatic int sat_max(input int len);
        return (2 ** (len - 1)) - 1;
    endfunction

    function automatic int sat_min(input int len);
        return -(2 ** (len - 1));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head data: rdata_o always holds the oldest entry.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d, rd_next;
    logic [AW:0]      lvl_q, lvl_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             do_push, do_pop;

    assign empty_o = (lvl_q == '0);
    assign full_o  = (lvl_q == (AW + 1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rd_next = rd_q + AW'(1);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        lvl_d   = lvl_q;
        rdata_d = rdata_q;
        if (do_push) wr_d = wr_q + AW'(1);
        if (do_pop)  rd_d = rd_next;
        case ({do_push, do_pop})
            2'b10:   lvl_d = lvl_q + (AW + 1)'(1);
            2'b01:   lvl_d = lvl_q - (AW + 1)'(1);
            default: lvl_d = lvl_q;
        endcase
        // Head register reloads from memory, or straight from wdata when the
        // pushed word becomes the new head in the same edge.
        if (do_pop) begin
            if (lvl_q > (AW + 1)'(1)) rdata_d = mem_q[rd_next];
            else if (do_push)         rdata_d = wdata_i;
        end else if (do_push && empty_o) begin
            rdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            lvl_q   <= '0;
            rdata_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            lvl_q   <= lvl_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = rdata_q;
    assign level_o = lvl_q;

endmodule

// File: rtl/iir_out_decim.sv
// IIR output stage: keeps 1 of every decim+1 valid samples, rounds half-up and
// saturates to the output format, then buffers results in a FIFO with sticky overflow.
module iir_out_decim
    import iir_pkg::*;
#(
    parameter int IN_LEN   = IIR_IN_LEN,
    parameter int IN_FRAC  = IIR_IN_FRAC,
    parameter int OUT_LEN  = IIR_OUT_LEN,
    parameter int OUT_FRAC = IIR_OUT_FRAC,
    parameter int DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [IN_LEN-1:0]        in_data,
    input  logic [3:0]               decim,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_LEN-1:0]       out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int SH = IN_FRAC - OUT_FRAC;
    localparam int W  = IN_LEN + 1;
    localparam logic signed [W-1:0] RND    = (SH > 0) ? W'(1 << (SH - 1)) : '0;
    localparam logic signed [W-1:0] LIM_HI = W'(sat_max(OUT_LEN));
    localparam logic signed [W-1:0] LIM_LO = W'(sat_min(OUT_LEN));

    logic [3:0]         cnt_q, cnt_d, lim_q, lim_d;
    logic               keep;
    logic signed [W-1:0] ext, rnd;
    sat_e               sat_sel;
    logic [OUT_LEN-1:0] sat_data;
    logic               stg_vld_q;
    logic [OUT_LEN-1:0] stg_data_q;
    logic               ovf_q, ovf_d;
    logic               fifo_full, fifo_empty;

    // The limit is re-latched only on a kept sample, so decim changes land at the next wrap.
    always_comb begin
        cnt_d = cnt_q;
        lim_d = lim_q;
        keep  = 1'b0;
        if (in_valid) begin
            if (cnt_q == '0) begin
                keep  = 1'b1;
                lim_d = decim;
                cnt_d = (decim == '0) ? '0 : 4'd1;
            end else if (cnt_q == lim_q) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        ext      = $signed({in_data[IN_LEN-1], in_data});
        rnd      = (ext + RND) >>> SH;
        sat_sel  = SAT_PASS;
        if (rnd > LIM_HI)      sat_sel = SAT_POS;
        else if (rnd < LIM_LO) sat_sel = SAT_NEG;
        case (sat_sel)
            SAT_POS: sat_data = LIM_HI[OUT_LEN-1:0];
            SAT_NEG: sat_data = LIM_LO[OUT_LEN-1:0];
            default: sat_data = rnd[OUT_LEN-1:0];
        endcase
    end

    // A stage word arriving at a full FIFO with no pop is dropped; set beats clear.
    always_comb begin
        ovf_d = ovf_q;
        if (stg_vld_q && fifo_full && !out_ready) ovf_d = 1'b1;
        else if (ovf_clr)                         ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            lim_q      <= '0;
            stg_vld_q  <= 1'b0;
            stg_data_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            lim_q     <= lim_d;
            stg_vld_q <= keep;
            if (keep) stg_data_q <= sat_data;
            ovf_q     <= ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (OUT_LEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (stg_vld_q),
        .wdata_i (stg_data_q),
        .pop_i   (out_ready),
        .rdata_o (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign out_valid = !fifo_empty;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_iir_out_decim.sv
// Randomised and directed checks of iir_out_decim against a queue-based reference model.
module tb_iir_out_decim;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, ovf_clr;
    logic [16:0] in_data;
    logic [3:0]  decim;
    logic        out_valid, ovf;
    logic [15:0] out_data;
    logic [3:0]  level;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int  mq[$];
    bit  m_ovf;
    int  m_cnt, m_lim;
    bit  m_sv;
    int  m_sd;
    int  popped[$];

    always #5 clk = ~clk;

    iir_out_decim #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .decim     (decim),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Round half-up to one fewer fraction bit (floor((x+1)/2)), then clamp to 16-bit signed.
    function automatic int ref_round(input logic [16:0] d);
        int x, y, r;
        x = int'($signed(d));
        y = x + 1;
        r = (y >= 0) ? (y / 2) : -((-y + 1) / 2);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r & 32'hFFFF;
    endfunction

    task automatic cycle();
        bit pop, drop, keep;
        if (out_valid && out_ready) popped.push_back(int'(out_data));
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_cnt = 0; m_lim = 0; m_sv = 0;
        end else begin
            pop  = out_ready && (mq.size() > 0);
            drop = 0;
            if (pop) void'(mq.pop_front());
            if (m_sv) begin
                if (mq.size() < DEPTH) mq.push_back(m_sd);
                else drop = 1;
            end
            if (drop)         m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            keep = 0;
            if (in_valid) begin
                if (m_cnt == 0) begin
                    m_lim = int'(decim);
                    keep  = 1;
                end
                m_cnt = (m_cnt + 1) % (m_lim + 1);
            end
            m_sv = keep;
            if (keep) m_sd = ref_round(in_data);
        end
        #1;
        check("out_valid", out_valid, (mq.size() > 0));
        check("level", level, mq.size());
        check("ovf", ovf, m_ovf);
        if (mq.size() > 0) check("out_data", out_data, mq[0]);
        if (rst) check("rst_out_data", out_data, 0);
    endtask

    task automatic drive(input bit v, input logic [16:0] d);
        in_valid = v;
        in_data  = d;
    endtask

    task automatic idle(input int n);
        drive(0, '0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1; in_valid = 0; in_data = '0; decim = '0; out_ready = 0; ovf_clr = 0;
        m_ovf = 0; m_cnt = 0; m_lim = 0; m_sv = 0; m_sd = 0;
        cycle(); cycle();
        rst = 0;
        idle(2);

        // decim=0, constant input, latency two edges
        out_ready = 1; popped.delete();
        drive(1, 17'h02001); cycle();
        check("lat1_valid", out_valid, 0);
        cycle();
        check("lat2_valid", out_valid, 1);
        check("lat2_data", out_data, 16'h1001);
        for (int i = 0; i < 4; i++) cycle();
        idle(4);
        check("d0_count", popped.size(), 6);
        foreach (popped[i]) check("d0_data", popped[i], 16'h1001);

        // decim=3 keeps samples 1, 5, 9
        popped.delete(); decim = 4'd3;
        for (int i = 1; i <= 12; i++) begin drive(1, 17'(i)); cycle(); end
        decim = 4'd0; idle(4);
        check("d3_count", popped.size(), 3);
        if (popped.size() == 3) begin
            check("d3_k0", popped[0], 16'h0001);
            check("d3_k1", popped[1], 16'h0003);
            check("d3_k2", popped[2], 16'h0005);
        end

        // saturation and rounding corners
        popped.delete();
        drive(1, 17'h0FFFF); cycle();
        drive(1, 17'h10000); cycle();
        drive(1, 17'h1FFFF); cycle();
        idle(4);
        check("sat_count", popped.size(), 3);
        if (popped.size() == 3) begin
            check("sat_pos", popped[0], 16'h7FFF);
            check("sat_neg", popped[1], 16'h8000);
            check("rnd_m1", popped[2], 16'h0000);
        end

        // overflow: nine pushes into eight entries
        out_ready = 0; popped.delete();
        for (int k = 1; k <= 9; k++) begin drive(1, 17'(2 * k)); cycle(); end
        idle(2);
        check("ovf_level", level, 8);
        check("ovf_set", ovf, 1);
        ovf_clr = 1; cycle(); ovf_clr = 0;
        check("ovf_clr", ovf, 0);

        // full FIFO with simultaneous pop and push
        drive(1, 17'(2 * 8'h55)); cycle();
        drive(0, '0); out_ready = 1; cycle();
        check("fullpp_level", level, 8);
        check("fullpp_ovf", ovf, 0);
        idle(10);
        check("drain_count", popped.size(), 9);
        if (popped.size() == 9) begin
            for (int k = 0; k < 8; k++) check("drain_order", popped[k], k + 1);
            check("drain_last", popped[8], 16'h0055);
        end

        // reset mid-operation with occupied FIFO and a live stage word
        out_ready = 0; popped.delete();
        for (int k = 0; k < 6; k++) begin drive(1, 17'(2 * (k + 20))); cycle(); end
        check("pre_rst_level", level, 5);
        drive(0, '0); rst = 1; cycle(); rst = 0;
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_ovf", ovf, 0);
        out_ready = 1; idle(4);
        check("rst_no_stale", popped.size(), 0);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = 17'($urandom);
            if ($urandom_range(0, 19) == 0) decim = 4'($urandom_range(0, 4));
            out_ready = ($urandom_range(0, 2) == 0);
            ovf_clr   = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 249) == 0);
            cycle();
        end
        rst = 0; ovf_clr = 0;
        out_ready = 1; idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
